// File: rtl/rms_sqrt_backend.sv
// RMS back-end: restoring divide of sum-of-squares by count, digit-by-digit integer sqrt,
// result queued in a DEPTH-entry FIFO with a registered read port.
module rms_sqrt_backend #(
  parameter int INPUT       = 32,
  parameter int COUNTERBITS = 8,
  parameter int OUTPUT      = 32,
  parameter int DEPTH       = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              valid_in,
  input  logic [2*INPUT+COUNTERBITS-1:0]    numerator_in,
  input  logic [COUNTERBITS-1:0]            denominator_in,
  input  logic                              read,
  output logic [OUTPUT-1:0]                 dataout,
  output logic                              empty,
  output logic                              full,
  output logic                              busy
);

  localparam int NW = 2*INPUT + COUNTERBITS;
  localparam int QW = 2*OUTPUT;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(((NW > OUTPUT) ? NW : OUTPUT) + 1);

  typedef enum logic [2:0] {S_IDLE, S_DIV, S_SQLD, S_SQRT, S_WR} state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [NW-1:0]          div_q;
  logic [COUNTERBITS-1:0] div_r;
  logic [COUNTERBITS-1:0] den_r;
  logic                   quotient_valid;
  logic [QW-1:0]          sq_rad;
  logic [OUTPUT-1:0]      sq_root;
  logic [OUTPUT-1:0]      sq_rem;
  logic                   root_valid;

  logic [COUNTERBITS:0]   div_sh;
  logic                   div_ge;
  logic [OUTPUT+1:0]      sq_sh;
  logic [OUTPUT+1:0]      sq_trial;
  logic                   sq_ge;

  assign div_sh   = {div_r, div_q[NW-1]};
  assign div_ge   = (div_sh >= {1'b0, den_r});
  // Partial remainder stays below 2*root, so OUTPUT bits suffice until the final step.
  assign sq_sh    = {sq_rem, sq_rad[QW-1:QW-2]};
  assign sq_trial = {sq_root, 2'b01};
  assign sq_ge    = (sq_sh >= sq_trial);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      div_q          <= '0;
      div_r          <= '0;
      den_r          <= '0;
      quotient_valid <= 1'b0;
      sq_rad         <= '0;
      sq_root        <= '0;
      sq_rem         <= '0;
      root_valid     <= 1'b0;
      busy           <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (valid_in) begin
            div_q <= numerator_in;
            div_r <= '0;
            den_r <= denominator_in;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_DIV;
          end
        end
        S_DIV: begin
          div_q <= {div_q[NW-2:0], div_ge};
          div_r <= div_ge ? COUNTERBITS'(div_sh - {1'b0, den_r}) : div_sh[COUNTERBITS-1:0];
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(NW-1)) begin
            quotient_valid <= 1'b1;
            state          <= S_SQLD;
          end
        end
        S_SQLD: begin
          quotient_valid <= 1'b0;
          if (quotient_valid) begin
            // Zero divisor yields 0; a quotient wider than QW saturates.
            if (den_r == '0)             sq_rad <= '0;
            else if (|div_q[NW-1:QW])    sq_rad <= '1;
            else                         sq_rad <= div_q[QW-1:0];
            sq_root <= '0;
            sq_rem  <= '0;
            cnt     <= '0;
            state   <= S_SQRT;
          end
        end
        S_SQRT: begin
          sq_rad  <= {sq_rad[QW-3:0], 2'b00};
          sq_root <= {sq_root[OUTPUT-2:0], sq_ge};
          sq_rem  <= sq_ge ? OUTPUT'(sq_sh - sq_trial) : sq_sh[OUTPUT-1:0];
          cnt     <= cnt + 1'b1;
          if (cnt == CW'(OUTPUT-1)) begin
            root_valid <= 1'b1;
            state      <= S_WR;
          end
        end
        S_WR: begin
          root_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic [OUTPUT-1:0] mem [DEPTH];
  logic [AW:0]       wptr;
  logic [AW:0]       rptr;
  logic              do_wr;
  logic              do_rd;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  // A write arriving while full is dropped even if a read frees a slot this cycle.
  assign do_wr = root_valid && !full;
  assign do_rd = read && !empty;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr[AW-1:0]] <= sq_root;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      dataout <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) begin
        rptr    <= rptr + 1'b1;
        dataout <= mem[rptr[AW-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_rms_sqrt_backend.sv
// Directed bench for rms_sqrt_backend: table of RMS vectors plus FIFO, reset and busy sequences.
module tb_rms_sqrt_backend;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic [71:0] numerator_in;
  logic [7:0]  denominator_in;
  logic        read;
  logic [31:0] dataout;
  logic        empty;
  logic        full;
  logic        busy;

  int checks;
  int failures;

  rms_sqrt_backend dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .numerator_in(numerator_in),
    .denominator_in(denominator_in), .read(read), .dataout(dataout),
    .empty(empty), .full(full), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] num;
    logic [7:0]  den;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_req(input logic [71:0] n, input logic [7:0] d);
    @(negedge clk);
    numerator_in   = n;
    denominator_in = d;
    valid_in       = 1'b1;
    @(negedge clk);
    valid_in       = 1'b0;
  endtask

  // Returns number of negedges after the request edge until busy drops.
  task automatic wait_idle(output int k);
    k = 0;
    while (busy && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) check("idle_timeout", 72'd1, 72'd0);
  endtask

  task automatic do_read();
    @(negedge clk);
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
  endtask

  initial begin
    int lat;
    bit seen_write;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    valid_in = 1'b0;
    numerator_in = '0;
    denominator_in = '0;
    read = 1'b0;

    vecs[0] = '{72'd100, 8'd4, 32'd5};
    vecs[1] = '{72'd10, 8'd3, 32'd1};
    vecs[2] = '{72'd99, 8'd1, 32'd9};
    vecs[3] = '{72'd50, 8'd0, 32'd0};
    vecs[4] = '{{72{1'b1}}, 8'd1, 32'hFFFF_FFFF};
    vecs[5] = '{{8'h00, {64{1'b1}}}, 8'd1, 32'hFFFF_FFFF};
    vecs[6] = '{72'h1_0000_0000_0000_0000, 8'd1, 32'hFFFF_FFFF};
    vecs[7] = '{72'd1600, 8'd16, 32'd10};
    vecs[8] = '{72'd17, 8'd255, 32'd0};
    vecs[9] = '{72'd1000000, 8'd1, 32'd1000};

    repeat (3) @(negedge clk);
    check("reset_dataout", dataout, 0);
    check("reset_empty", empty, 1);
    check("reset_full", full, 0);
    check("reset_busy", busy, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      pulse_req(vecs[i].num, vecs[i].den);
      check($sformatf("vec%0d_busy_rise", i), busy, 1);
      wait_idle(lat);
      check($sformatf("vec%0d_latency", i), lat, 106);
      check($sformatf("vec%0d_not_empty", i), empty, 0);
      do_read();
      check($sformatf("vec%0d_dataout", i), dataout, vecs[i].exp);
      check($sformatf("vec%0d_empty_after", i), empty, 1);
    end

    // Fill: 17 results, the last one must be dropped.
    for (int k = 1; k <= 17; k++) begin
      pulse_req(72'(k * k), 8'd1);
      wait_idle(lat);
      if (k == 15) check("fill_full_at15", full, 0);
      if (k == 16) check("fill_full_at16", full, 1);
      if (k == 17) check("fill_full_at17", full, 1);
    end
    for (int k = 1; k <= 16; k++) begin
      do_read();
      check($sformatf("drain_%0d", k), dataout, k);
      if (k == 1) check("drain_full_clear", full, 0);
    end
    check("drain_empty", empty, 1);
    do_read();
    check("read_empty_hold", dataout, 16);
    check("read_empty_stays", empty, 1);

    // Read on the same edge as a write with one entry present.
    pulse_req(72'd49, 8'd1);
    wait_idle(lat);
    pulse_req(72'd64, 8'd1);
    repeat (105) @(negedge clk);
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    check("rw_older_first", dataout, 7);
    check("rw_count_one", empty, 0);
    check("rw_busy_low", busy, 0);
    do_read();
    check("rw_second", dataout, 8);
    check("rw_empty_after", empty, 1);

    // Reset at E+50 aborts the computation.
    pulse_req(72'd100, 8'd4);
    repeat (49) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    seen_write = 1'b0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (!empty || busy) seen_write = 1'b1;
    end
    check("abort_no_write", seen_write, 0);
    check("abort_empty", empty, 1);
    check("abort_dataout", dataout, 0);

    // valid_in at E+10 while busy is ignored.
    pulse_req(72'd36, 8'd1);
    repeat (9) @(negedge clk);
    numerator_in = 72'd81;
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    wait_idle(lat);
    check("ignore_latency", lat, 96);
    repeat (150) @(negedge clk);
    check("ignore_busy_low", busy, 0);
    do_read();
    check("ignore_result", dataout, 6);
    check("ignore_single", empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
